// File: rtl/fft_frame_sequencer_pkg.sv
// Shared definitions for the FFT frame sequencer: controller state encoding
// and fixed-point frame/lane width helpers.
package fft_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic int frame_width(input int n, input int int_bits, input int dec_bits);
    return n * (int_bits + dec_bits);
  endfunction

  // Two's-complement full-scale codes of an lw-bit lane, zero-extended to 64 bits
  function automatic logic [63:0] lane_max(input int lw);
    return (64'd1 << (lw - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] lane_min(input int lw);
    return 64'd1 << (lw - 1);
  endfunction

endpackage

// File: rtl/fft_valid_delay.sv
// Valid shift register matching the FFT core latency; also reports whether
// any issued frame is still in flight.
module fft_valid_delay #(
  parameter int LATENCY = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid,
  output logic pending
);

  logic [LATENCY-1:0] pipe_r;

  // Shift the issue strobe along the latency pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_r <= '0;
    end else begin
      pipe_r[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign out_valid = pipe_r[LATENCY-1];
  assign pending   = |pipe_r;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Streams a host-written bank of input frames into an external FFT core and
// captures the latency-matched results into a host-readable output bank.
module fft_frame_sequencer
  import fft_frame_sequencer_pkg::*;
#(
  parameter int INT     = 4,
  parameter int DEC     = 4,
  parameter int N       = 32,
  parameter int FRAMES  = 8,
  parameter int LATENCY = 5,
  parameter int CW      = 16,
  localparam int W      = frame_width(N, INT, DEC),
  localparam int AW     = $clog2(FRAMES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic          in_wr_en,
  input  logic [AW-1:0] in_wr_addr,
  input  logic [W-1:0]  in_wr_real,
  input  logic [W-1:0]  in_wr_imag,
  output logic [W-1:0]  xn_real,
  output logic [W-1:0]  xn_imag,
  output logic          xn_valid,
  input  logic [W-1:0]  xk_real,
  input  logic [W-1:0]  xk_imag,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_real,
  output logic [W-1:0]  rd_imag,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] frame_cnt,
  output logic          sat_flag
);

  localparam int LW = INT + DEC;
  localparam logic [LW-1:0] LANE_MAX  = LW'(lane_max(LW));
  localparam logic [LW-1:0] LANE_MIN  = LW'(lane_min(LW));
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAMES - 1);

  logic [W-1:0] in_real_bank  [FRAMES];
  logic [W-1:0] in_imag_bank  [FRAMES];
  logic [W-1:0] out_real_bank [FRAMES];
  logic [W-1:0] out_imag_bank [FRAMES];

  seq_state_e    state_r, state_s;
  logic          issue_s, run_start_s, cap_valid_s, pending_s, sat_s;
  logic          mode_r, busy_r, done_r, xn_valid_r, sat_r;
  logic [AW-1:0] feed_addr_r, cap_addr_r;
  logic [CW-1:0] frame_cnt_r;
  logic [W-1:0]  xn_real_r, xn_imag_r, rd_real_r, rd_imag_r;

  function automatic logic any_full_scale(input logic [W-1:0] v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((v[i*LW +: LW] == LANE_MAX) || (v[i*LW +: LW] == LANE_MIN)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  fft_valid_delay #(.LATENCY(LATENCY)) u_valid_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_s),
    .out_valid (cap_valid_s),
    .pending   (pending_s)
  );

  assign sat_s = any_full_scale(xk_real) | any_full_scale(xk_imag);

  // Next-state decode; a frame is issued on every FEED cycle
  always_comb begin
    state_s     = state_r;
    issue_s     = 1'b0;
    run_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s     = ST_FEED;
          run_start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FEED: begin
        issue_s = 1'b1;
        if (stop || (!mode_r && (feed_addr_r == LAST_ADDR))) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (!pending_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Control state, feed/capture pointers, status flags and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      xn_valid_r  <= 1'b0;
      sat_r       <= 1'b0;
      feed_addr_r <= '0;
      cap_addr_r  <= '0;
      frame_cnt_r <= '0;
      xn_real_r   <= '0;
      xn_imag_r   <= '0;
      rd_real_r   <= '0;
      rd_imag_r   <= '0;
    end else begin
      state_r    <= state_s;
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_DONE);
      xn_valid_r <= issue_s;
      rd_real_r  <= out_real_bank[rd_addr];
      rd_imag_r  <= out_imag_bank[rd_addr];
      if (issue_s) begin
        xn_real_r   <= in_real_bank[feed_addr_r];
        xn_imag_r   <= in_imag_bank[feed_addr_r];
        feed_addr_r <= feed_addr_r + AW'(1);
      end
      // Start and capture never coincide: a run only starts once drained
      if (run_start_s) begin
        mode_r      <= mode;
        feed_addr_r <= '0;
        cap_addr_r  <= '0;
        frame_cnt_r <= '0;
        sat_r       <= 1'b0;
      end else if (cap_valid_s) begin
        cap_addr_r  <= cap_addr_r + AW'(1);
        frame_cnt_r <= frame_cnt_r + CW'(1);
        if (sat_s) begin
          sat_r <= 1'b1;
        end
      end
    end
  end

  // Bank storage, left unreset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (in_wr_en && !busy_r) begin
      in_real_bank[in_wr_addr] <= in_wr_real;
      in_imag_bank[in_wr_addr] <= in_wr_imag;
    end
    if (cap_valid_s) begin
      out_real_bank[cap_addr_r] <= xk_real;
      out_imag_bank[cap_addr_r] <= xk_imag;
    end
  end

  assign xn_real   = xn_real_r;
  assign xn_imag   = xn_imag_r;
  assign xn_valid  = xn_valid_r;
  assign rd_real   = rd_real_r;
  assign rd_imag   = rd_imag_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign frame_cnt = frame_cnt_r;
  assign sat_flag  = sat_r;

endmodule
